stream_block_reducer: RTL and testbench

- Parametrised streaming reducer.
- Accepts DATA_W-bit words on a wen/rdy handshake and reduces each block of BLOCK_LEN words with a selectable operation: sum, XOR or unsigned max.
- Presents the result on dout with a one-cycle done pulse.
- Generalises the team's fixed 32-bit din/wen/rdy/dout/done block in width, block length and operation, and adds early block termination (flush).

---
 rtl/stream_block_reducer_if.sv | 25 ++
 rtl/stream_block_reducer.sv | 135 +++++++++++++
 tb/tb_stream_block_reducer.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/stream_block_reducer_if.sv
// Word-stream handshake and block-result bundle for stream_block_reducer.
// The ovf signal exists only when STREAM_BLOCK_REDUCER_OVF_EN is defined.
interface stream_block_reducer_if #(
  parameter int DATA_W    = 32,
  parameter int BLOCK_LEN = 16
);
  localparam int CW = $clog2(BLOCK_LEN + 1);

  logic [DATA_W-1:0] din;
  logic              wen;
  logic              flush;
  logic              rdy;
  logic [DATA_W-1:0] dout;
  logic [CW-1:0]     words;
  logic              done;
`ifdef STREAM_BLOCK_REDUCER_OVF_EN
  logic              ovf;

  modport master (output din, wen, flush, input rdy, dout, words, done, ovf);
  modport slave  (input din, wen, flush, output rdy, dout, words, done, ovf);
`else
  modport master (output din, wen, flush, input rdy, dout, words, done);
  modport slave  (input din, wen, flush, output rdy, dout, words, done);
`endif
endinterface

// File: rtl/stream_block_reducer.sv
// Streaming block reducer (sum / XOR / unsigned max) with early flush.
// Optional sum-overflow flag on ovf when STREAM_BLOCK_REDUCER_OVF_EN is defined.
module stream_block_reducer #(
  parameter int DATA_W    = 32,
  parameter int BLOCK_LEN = 16,
  parameter int MODE      = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  stream_block_reducer_if.slave bus
);
  localparam int CW = $clog2(BLOCK_LEN + 1);
  localparam logic [CW-1:0] LEN = CW'(BLOCK_LEN);

  generate
    if (MODE < 0 || MODE > 2) begin : g_bad_mode
      $error("stream_block_reducer: MODE must be 0, 1 or 2");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] acc;
  logic              take;
  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] op_res;
  logic [DATA_W-1:0] acc_nxt;
  logic [CW-1:0]     cnt_nxt;
  logic              close;

  assign take = bus.wen && bus.rdy;

`ifdef STREAM_BLOCK_REDUCER_OVF_EN
  logic [DATA_W:0] sum_ext;
  logic            carry;
  logic            flag;
  logic            flag_nxt;

  assign sum_ext = {1'b0, acc} + {1'b0, bus.din};
  assign sum     = sum_ext[DATA_W-1:0];
  assign carry   = sum_ext[DATA_W];
`else
  assign sum = acc + bus.din;
`endif

  always_comb begin
    case (MODE)
      0:       op_res = sum;
      1:       op_res = acc ^ bus.din;
      default: op_res = (bus.din > acc) ? bus.din : acc;
    endcase
  end

  // Next accumulator/count and whether this edge closes the block.
  always_comb begin
    acc_nxt = acc;
    cnt_nxt = cnt;
    close   = 1'b0;
    case (state)
      IDLE: begin
        if (take) begin
          acc_nxt = bus.din;
          cnt_nxt = CW'(1);
          close   = bus.flush;
        end
      end
      ACC: begin
        if (take) begin
          acc_nxt = op_res;
          cnt_nxt = cnt + 1'b1;
        end
        close = bus.flush || (take && (cnt_nxt == LEN));
      end
      default: ;
    endcase
  end

`ifdef STREAM_BLOCK_REDUCER_OVF_EN
  always_comb begin
    flag_nxt = flag;
    if (take) begin
      if (state == IDLE)
        flag_nxt = 1'b0;
      else if (state == ACC)
        flag_nxt = flag | ((MODE == 0) && carry);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      bus.rdy   <= 1'b0;
      bus.done  <= 1'b0;
      bus.dout  <= '0;
      bus.words <= '0;
`ifdef STREAM_BLOCK_REDUCER_OVF_EN
      flag      <= 1'b0;
      bus.ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        OUT: begin
          state    <= IDLE;
          cnt      <= '0;
          bus.rdy  <= 1'b1;
          bus.done <= 1'b0;
        end
        default: begin
          acc      <= acc_nxt;
          cnt      <= cnt_nxt;
          bus.rdy  <= !close;
          bus.done <= close;
`ifdef STREAM_BLOCK_REDUCER_OVF_EN
          flag     <= flag_nxt;
`endif
          if (close) begin
            state     <= OUT;
            bus.dout  <= acc_nxt;
            bus.words <= cnt_nxt;
`ifdef STREAM_BLOCK_REDUCER_OVF_EN
            bus.ovf   <= (MODE == 0) && flag_nxt;
`endif
          end else if (take) begin
            state <= ACC;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_stream_block_reducer.sv
// Bench for stream_block_reducer: one shared input stream drives sum, XOR and
// max instances; a block-level model (queue of accepted words) predicts outputs.
module tb_stream_block_reducer;
  localparam int DW = 32;
  localparam int BL = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] din;
  logic          wen;
  logic          flush;

  int n_checks = 0;
  int n_err    = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  stream_block_reducer_if #(.DATA_W(DW), .BLOCK_LEN(BL)) if0 ();
  stream_block_reducer_if #(.DATA_W(DW), .BLOCK_LEN(BL)) if1 ();
  stream_block_reducer_if #(.DATA_W(DW), .BLOCK_LEN(BL)) if2 ();

  assign if0.din = din;  assign if0.wen = wen;  assign if0.flush = flush;
  assign if1.din = din;  assign if1.wen = wen;  assign if1.flush = flush;
  assign if2.din = din;  assign if2.wen = wen;  assign if2.flush = flush;

  stream_block_reducer #(.DATA_W(DW), .BLOCK_LEN(BL), .MODE(0)) u_sum (.clk(clk), .rst_n(rst_n), .bus(if0));
  stream_block_reducer #(.DATA_W(DW), .BLOCK_LEN(BL), .MODE(1)) u_xor (.clk(clk), .rst_n(rst_n), .bus(if1));
  stream_block_reducer #(.DATA_W(DW), .BLOCK_LEN(BL), .MODE(2)) u_max (.clk(clk), .rst_n(rst_n), .bus(if2));

  // Reference model: words of the open block, and the last reported results.
  logic [DW-1:0] q[$];
  bit            m_rdy;
  bit            m_done;
  logic [DW-1:0] m_dout[3];
  int            m_words;
  bit            m_ovf;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] reduce(input int mode);
    logic [DW-1:0] r;
    r = q[0];
    for (int i = 1; i < q.size(); i++) begin
      case (mode)
        0:       r = r + q[i];
        1:       r = r ^ q[i];
        default: if (q[i] > r) r = q[i];
      endcase
    end
    return r;
  endfunction

  function automatic bit sum_overflows();
    longint unsigned s;
    s = 0;
    foreach (q[i]) s += longint'(q[i]);
    return s >= 64'h1_0000_0000;
  endfunction

  task automatic model_reset();
    q.delete();
    m_rdy   = 0;
    m_done  = 0;
    m_words = 0;
    m_ovf   = 0;
    for (int k = 0; k < 3; k++) m_dout[k] = '0;
  endtask

  task automatic model_edge(input logic w, input logic [DW-1:0] d, input logic f);
    if (w && m_rdy) q.push_back(d);
    if (q.size() > 0 && (q.size() == BL || f)) begin
      for (int k = 0; k < 3; k++) m_dout[k] = reduce(k);
      m_words = q.size();
      m_ovf   = sum_overflows();
      m_done  = 1;
      m_rdy   = 0;
      q.delete();
    end else begin
      m_done = 0;
      m_rdy  = 1;
    end
  endtask

  task automatic compare();
    check("rdy_sum",   if0.rdy,   m_rdy);
    check("rdy_xor",   if1.rdy,   m_rdy);
    check("rdy_max",   if2.rdy,   m_rdy);
    check("done_sum",  if0.done,  m_done);
    check("done_xor",  if1.done,  m_done);
    check("done_max",  if2.done,  m_done);
    check("dout_sum",  if0.dout,  m_dout[0]);
    check("dout_xor",  if1.dout,  m_dout[1]);
    check("dout_max",  if2.dout,  m_dout[2]);
    check("words_sum", if0.words, m_words);
    check("words_xor", if1.words, m_words);
    check("words_max", if2.words, m_words);
`ifdef STREAM_BLOCK_REDUCER_OVF_EN
    check("ovf_sum",   if0.ovf,   m_ovf);
    check("ovf_xor",   if1.ovf,   1'b0);
    check("ovf_max",   if2.ovf,   1'b0);
`endif
  endtask

  // Drive at the negedge, model the posedge, sample at the following negedge.
  task automatic cycle(input logic w, input logic [DW-1:0] d, input logic f);
    wen = w; din = d; flush = f;
    @(posedge clk);
    model_edge(w, d, f);
    @(negedge clk);
    if (if0.done) done_cnt++;
    compare();
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    wen = 1'b0; flush = 1'b0;
    @(negedge clk);
    model_reset();
    compare();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; din = '0; wen = 1'b0; flush = 1'b0;
    model_reset();
    repeat (10) @(negedge clk);
    compare();
    check("reset_rdy", if0.rdy, 1'b0);
    check("reset_dout", if0.dout, 32'd0);
    rst_n = 1'b1;
    cycle(0, 0, 0);
    check("rdy_after_reset", if0.rdy, 1'b1);

    // Full sum block.
    cycle(1, 1, 0); cycle(1, 2, 0); cycle(1, 3, 0); cycle(1, 4, 0);
    check("full_done", if0.done, 1'b1);
    check("full_dout", if0.dout, 32'd10);
    check("full_words", if0.words, 3'd4);
    check("full_rdy_out", if0.rdy, 1'b0);
    cycle(0, 0, 0);
    check("full_rdy_next", if0.rdy, 1'b1);
    check("hold_dout", if0.dout, 32'd10);

    // Wrap and overflow.
    cycle(1, 32'hFFFF_FFFF, 0); cycle(1, 2, 0); cycle(1, 0, 0); cycle(1, 0, 0);
    check("wrap_dout", if0.dout, 32'd1);
`ifdef STREAM_BLOCK_REDUCER_OVF_EN
    check("wrap_ovf", if0.ovf, 1'b1);
`endif
    cycle(0, 0, 0);
    cycle(1, 1, 0); cycle(1, 1, 0); cycle(1, 1, 0); cycle(1, 1, 0);
    check("ones_dout", if0.dout, 32'd4);
`ifdef STREAM_BLOCK_REDUCER_OVF_EN
    check("ones_ovf", if0.ovf, 1'b0);
`endif
    cycle(0, 0, 0);

    // Flush with coincident word, then flush alone in IDLE.
    cycle(1, 32'hA5, 0); cycle(1, 32'h0F, 1);
    check("flush_done", if1.done, 1'b1);
    check("flush_dout", if1.dout, 32'hAA);
    check("flush_words", if1.words, 3'd2);
    cycle(0, 0, 0);
    done_cnt = 0;
    cycle(0, 0, 1); cycle(0, 0, 1);
    check("idle_flush_no_done", done_cnt, 0);

    // Gapped max block, word offered during OUT is lost.
    cycle(1, 7, 0); cycle(0, 0, 0); cycle(0, 0, 0); cycle(0, 0, 0);
    cycle(1, 3, 0); cycle(1, 9, 0); cycle(1, 9, 0);
    check("max_dout", if2.dout, 32'd9);
    check("max_words", if2.words, 3'd4);
    cycle(1, 100, 0);
    cycle(1, 1, 0); cycle(1, 1, 0); cycle(1, 1, 0); cycle(1, 1, 0);
    check("max_after_lost", if2.dout, 32'd1);
    check("max_after_words", if2.words, 3'd4);
    cycle(0, 0, 0);

    // Reset mid-block discards the partial block.
    done_cnt = 0;
    cycle(1, 2, 0); cycle(1, 2, 0);
    pulse_reset();
    cycle(0, 0, 0);
    cycle(1, 5, 0); cycle(1, 5, 0); cycle(1, 5, 0); cycle(1, 5, 0);
    check("midrst_dout", if0.dout, 32'd20);
    check("midrst_words", if0.words, 3'd4);
    cycle(0, 0, 0);
    check("midrst_one_done", done_cnt, 1);

    // Randomized traffic against the block model.
    for (int n = 0; n < 3000; n++) begin
      logic [DW-1:0] d;
      case ($urandom_range(0, 3))
        0:       d = $urandom;
        1:       d = DW'($urandom_range(0, 15));
        2:       d = 32'hFFFF_FFF0 + DW'($urandom_range(0, 15));
        default: d = '0;
      endcase
      if ($urandom_range(0, 599) == 0) pulse_reset();
      else cycle($urandom_range(0, 9) < 7, d, $urandom_range(0, 11) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
